// File: rtl/fir_sample_pacer.sv
// Sample pacer for an FIR filter input: buffers source samples in a small FIFO
// and releases one registered sample every RATE clocks once half full.
module fir_sample_pacer #(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned RATE  = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [W-1:0]             in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [W-1:0]             out_sample,
   output logic                     out_strobe,
   input  logic                     clr_ufl,
   output logic                     underflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned RW = $clog2(RATE);

   typedef enum logic {FILL, RUN} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [RW-1:0]   rate_q, rate_d;
   logic [W-1:0]    out_q, out_d;
   logic            strobe_q, strobe_d;
   logic            ufl_q, ufl_d;

   logic            push, tick, pop, ufl_set;

   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rstn) state_q <= FILL;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (count_q >= CW'(DEPTH / 2)) state_d = RUN;
         RUN:     if (ufl_set) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // A tick with an empty FIFO is an underflow even if a push lands on the same edge.
   always_comb begin
      tick    = (state_q == RUN) && (rate_q == RW'(RATE - 1));
      pop     = tick && (count_q != '0);
      ufl_set = tick && (count_q == '0);
      rate_d  = '0;
      if (state_q == RUN && state_d == RUN)
         rate_d = tick ? '0 : rate_q + RW'(1);
   end

   always_comb begin
      rd_d     = pop  ? rd_q + AW'(1) : rd_q;
      wr_d     = push ? wr_q + AW'(1) : wr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      out_d    = pop ? mem_q[rd_q] : out_q;
      strobe_d = pop;
      ufl_d    = ufl_q;
      if (ufl_set)      ufl_d = 1'b1;
      else if (clr_ufl) ufl_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         rd_q     <= '0;
         wr_q     <= '0;
         count_q  <= '0;
         rate_q   <= '0;
         out_q    <= '0;
         strobe_q <= 1'b0;
         ufl_q    <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         count_q  <= count_d;
         rate_q   <= rate_d;
         out_q    <= out_d;
         strobe_q <= strobe_d;
         ufl_q    <= ufl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn && push) mem_q[wr_q] <= in_data;
   end

   assign out_sample = out_q;
   assign out_strobe = strobe_q;
   assign underflow  = ufl_q;
   assign count      = count_q;

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed bench for fir_sample_pacer at W=4, DEPTH=4, RATE=8.
module tb_fir_sample_pacer;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] out_sample;
   logic       out_strobe;
   logic       clr_ufl = 1'b0;
   logic       underflow;
   logic [2:0] count;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   fir_sample_pacer #(.W(4), .DEPTH(4), .RATE(8)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_strobe (out_strobe),
      .clr_ufl    (clr_ufl),
      .underflow  (underflow),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   // gap-1 quiet cycles, then a strobe carrying val
   task automatic pace(input int unsigned gap, input logic [3:0] val);
      int unsigned seen = 0;
      for (int unsigned i = 1; i < gap; i++) begin
         step();
         if (out_strobe) seen++;
      end
      chk("pace_quiet", seen, 0);
      step();
      chk("pace_strobe", out_strobe, 1);
      chk("pace_value", out_sample, val);
   endtask

   task automatic quiet_fill(input int unsigned cycles, input logic [2:0] exp_cnt);
      int unsigned seen = 0;
      for (int unsigned i = 0; i < cycles; i++) begin
         step();
         if (out_strobe) seen++;
      end
      chk("fill_no_pop", seen, 0);
      chk("fill_count", count, exp_cnt);
   endtask

   initial begin
      int unsigned cyc, last, got;
      logic [3:0]  vdat;
      logic        rdy;

      // reset held with a valid source present
      rstn = 1'b1; in_valid = 1'b1; in_data = 4'h9;
      repeat (3) step();
      chk("rst_out", out_sample, 0);
      chk("rst_count", count, 0);
      chk("rst_ufl", underflow, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_strobe", out_strobe, 0);
      rstn = 1'b0; in_valid = 1'b0;

      // prime with 1,2; RUN starts the edge after count=2, first pop 8 edges later
      in_valid = 1'b1; in_data = 4'd1; step();
      chk("prime_cnt1", count, 1);
      in_data = 4'd2; step();
      chk("prime_cnt2", count, 2);
      in_valid = 1'b0;
      pace(9, 4'd1);
      chk("prime_cnt_after", count, 1);
      push_one(4'd3);
      pace(7, 4'd2);
      push_one(4'd4);
      pace(7, 4'd3);
      pace(8, 4'd4);
      chk("drain_cnt", count, 0);

      // next tick finds the FIFO empty
      repeat (7) step();
      chk("ufl_before", underflow, 0);
      step();
      chk("ufl_set", underflow, 1);
      chk("ufl_hold_out", out_sample, 4'd4);
      chk("ufl_no_strobe", out_strobe, 0);
      push_one(4'd5);
      quiet_fill(16, 3'd1);
      clr_ufl = 1'b1; step(); clr_ufl = 1'b0;
      chk("ufl_clr", underflow, 0);

      rstn = 1'b1; step(); rstn = 1'b0;
      chk("rst2_count", count, 0);

      // backpressure: fill to 4, hold 9 until the first pop frees a slot
      in_valid = 1'b1;
      in_data = 4'd5; step();
      in_data = 4'd6; step();
      in_data = 4'd7; step();
      in_data = 4'd8; step();
      chk("bp_full_cnt", count, 4);
      chk("bp_full_ready", in_ready, 0);
      in_data = 4'd9;
      repeat (6) step();
      chk("bp_hold_cnt", count, 4);
      chk("bp_hold_ready", in_ready, 0);
      step();
      chk("bp_pop_out", out_sample, 4'd5);
      chk("bp_pop_strobe", out_strobe, 1);
      chk("bp_pop_cnt", count, 3);
      chk("bp_pop_ready", in_ready, 1);
      step();
      chk("bp_take9_cnt", count, 4);
      chk("bp_take9_ready", in_ready, 0);
      in_valid = 1'b0;
      pace(7, 4'd6);
      pace(8, 4'd7);
      pace(8, 4'd8);
      pace(8, 4'd9);
      chk("bp_end_cnt", count, 0);

      // reset while running with 3 queued
      in_valid = 1'b1;
      in_data = 4'd1; step();
      in_data = 4'd2; step();
      in_data = 4'd3; step();
      in_valid = 1'b0;
      chk("mid_cnt3", count, 3);
      rstn = 1'b1; step(); rstn = 1'b0;
      chk("mid_rst_cnt", count, 0);
      chk("mid_rst_out", out_sample, 0);
      chk("mid_rst_strobe", out_strobe, 0);
      chk("mid_rst_ready", in_ready, 1);
      push_one(4'd7);
      quiet_fill(16, 3'd1);

      // continuous ramp through the 4-bit wrap
      rstn = 1'b1; step(); rstn = 1'b0;
      vdat = '0; in_data = vdat; in_valid = 1'b1;
      cyc = 0; last = 0; got = 0;
      while (cyc < 400 && got < 20) begin
         rdy = in_ready;
         step();
         cyc++;
         if (rdy) begin
            vdat = vdat + 4'd1;
            in_data = vdat;
         end
         if (out_strobe) begin
            chk("wrap_value", out_sample, got[3:0]);
            if (got > 0) chk("wrap_gap", cyc - last, 8);
            last = cyc;
            got++;
         end
      end
      in_valid = 1'b0;
      chk("wrap_samples", got, 20);
      chk("wrap_ufl", underflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
